// File: rtl/sens_scan_fsm_if.sv
// Output sample stream of the sensor scan engine.
// Handshake: the source raises m_valid with m_data/m_user/m_last stable and
// keeps all of them unchanged until a rising clock edge sees
// m_valid & m_ready; that edge transfers exactly one sample. The sink may
// drive m_ready at any time, independent of m_valid.
interface sens_scan_fsm_if #(
  parameter int DATA_W = 16,
  parameter int SW     = 2
);
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [SW-1:0]     m_user;
  logic              m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_user,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_user,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/sens_scan_fsm.sv
// Frame scanner for a bank of ToF sensors: on each frame-ready pulse it
// reads every zone sample of every sensor out of a sample RAM, in raster or
// serpentine order, and forwards them one by one on a valid/ready stream.
module sens_scan_fsm #(
  parameter int  N_SENS = 4,
  parameter int  ROWS   = 8,
  parameter int  COLS   = 8,
  parameter int  DATA_W = 16,
  localparam int SW     = (N_SENS > 1) ? $clog2(N_SENS) : 1,
  localparam int RW     = $clog2(ROWS),
  localparam int CW     = $clog2(COLS),
  localparam int AW     = SW + RW + CW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              drdy,
  input  logic              mode,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  sens_scan_fsm_if.master   m_if,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic              overrun,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [SW-1:0] SENS_LAST = SW'(N_SENS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);

  state_e              state_q, state_d;
  logic [SW-1:0]       sens_q, sens_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   m_data_q, m_data_d;
  logic [SW-1:0]       m_user_q, m_user_d;
  logic                m_last_q, m_last_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                overrun_q, overrun_d;

  // Iterator geometry derived from the current position.
  logic                row_rev;       // current row is scanned right-to-left
  logic [CW-1:0]       col_end_val;   // final column of the current row
  logic                at_row_end;
  logic                at_last_row;
  logic                at_last_sens;
  logic                is_last;
  logic [RW-1:0]       row_inc;
  logic                next_row_rev;  // row after this one is scanned right-to-left

  assign row_rev      = mode_q & row_q[0];
  assign col_end_val  = row_rev ? '0 : COL_LAST;
  assign at_row_end   = (col_q == col_end_val);
  assign at_last_row  = (row_q == ROW_LAST);
  assign at_last_sens = (sens_q == SENS_LAST);
  assign is_last      = at_last_sens & at_last_row & at_row_end;
  assign row_inc      = row_q + RW'(1);
  assign next_row_rev = mode_q & row_inc[0];

  // State and datapath registers; everything clears on reset, which also
  // abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sens_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      mode_q      <= 1'b0;
      m_data_q    <= '0;
      m_user_q    <= '0;
      m_last_q    <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sens_q      <= sens_d;
      row_q       <= row_d;
      col_q       <= col_d;
      mode_q      <= mode_d;
      m_data_q    <= m_data_d;
      m_user_q    <= m_user_d;
      m_last_q    <= m_last_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next-state logic: one RAM read, one capture, then hold until accepted.
  always_comb begin
    state_d     = state_q;
    sens_d      = sens_q;
    row_d       = row_q;
    col_d       = col_q;
    mode_d      = mode_q;
    m_data_d    = m_data_q;
    m_user_d    = m_user_q;
    m_last_d    = m_last_q;
    frame_cnt_d = frame_cnt_q;
    // A frame-ready pulse while a scan is running is dropped but flagged.
    overrun_d   = drdy & (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (drdy) begin
          sens_d  = '0;
          row_d   = '0;
          col_d   = '0;
          mode_d  = mode;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_CAPTURE;
      end

      S_CAPTURE: begin
        // RAM data answers the read issued in the previous cycle.
        m_data_d = rd_data;
        m_user_d = sens_q;
        m_last_d = is_last;
        state_d  = S_HOLD;
      end

      S_HOLD: begin
        if (m_if.m_ready) begin
          if (m_last_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
            if (!at_row_end) begin
              col_d = row_rev ? (col_q - CW'(1)) : (col_q + CW'(1));
            end else if (!at_last_row) begin
              row_d = row_inc;
              col_d = next_row_rev ? COL_LAST : '0;
            end else begin
              sens_d = sens_q + SW'(1);
              row_d  = '0;
              col_d  = '0;
            end
          end
        end
      end

      S_DONE: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Iterators only move on the edge that enters ISSUE, so the address is
  // naturally held between reads.
  assign rd_en        = (state_q == S_ISSUE);
  assign rd_addr      = {sens_q, row_q, col_q};
  assign m_if.m_valid = (state_q == S_HOLD);
  assign m_if.m_data  = m_data_q;
  assign m_if.m_user  = m_user_q;
  assign m_if.m_last  = m_last_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_cnt    = frame_cnt_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule
